wire_alu_sequencer: RTL
=======================

Name: wire_alu_sequencer

Overview:
Command-execution stage between the host WireIn endpoints and the WireOut endpoints in the FrontPanel toplevel.
- Consumes a control wire and two operand wires.
- Executes one arithmetic command per rising edge of the start bit.
- Presents a double-width result and a status word on stable wires for the host to read.
- Multiply and multiply-accumulate run on a multi-cycle shift-add datapath. Outputs hold their previous values until a command completes, so asynchronous host reads never see partial results.

Parameters:
WIDTH, 16, operand width in bits; legal range 8..16; result width is 2*WIDTH.

Ports:
ti_clk  input  1  host interface clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
ctrl_wire  input  16  [0] start (edge-triggered), [1] clear (level), [3:2] op select, [15:4] ignored.
opa_wire  input  WIDTH  operand A, unsigned.
opb_wire  input  WIDTH  operand B, unsigned.
result_lo  output  WIDTH  low half of the result.
result_hi  output  WIDTH  high half of the result.
status_wire  output  16  [0] busy, [1] done, [2] overflow (sticky), [3] carry/borrow of last ADD/SUB, [7:4] 0, [15:8] ignored-start count.

Behaviour:
- Reset:
  - result_lo, result_hi, status_wire = 0.
  - Accumulator (2*WIDTH) = 0; state = IDLE.
  - Start-edge history register = 1, so a start bit already held high at reset release does not trigger.
- Start edge: detected in the cycle where ctrl_wire[0]=1 and the registered previous value is 0.
- Op select: 00 ADD, 01 SUB, 10 MUL, 11 MAC.
- States:
  - IDLE: on a start edge, latch opa_wire, opb_wire and ctrl_wire[3:2]; clear done; set busy; go to EXEC.
  - EXEC, ADD/SUB: one cycle, then DONE.
  - EXEC, MUL/MAC: one shift-add iteration per cycle, LSB of B first, WIDTH cycles, then DONE.
  - DONE: update result_lo/result_hi and flags; set done; clear busy; return to IDLE next cycle.
- Latency: edge cycle = N.
  - ADD/SUB results visible at N+2.
  - MUL/MAC results visible at N+WIDTH+1.
  - busy is high for cycles N+1 .. result cycle−1.
- ADD:
  - result_lo = (A+B) mod 2^WIDTH; result_hi = 0.
  - status[3] = carry out.
- SUB:
  - result_lo = (A−B) mod 2^WIDTH.
  - result_hi = all ones if A<B, else 0.
  - status[3] = borrow (A<B).
- MUL: {result_hi,result_lo} = A*B, exact (2*WIDTH bits); status[3] unchanged.
- MAC:
  - acc = (acc + A*B) mod 2^(2*WIDTH); {result_hi,result_lo} = new acc.
  - status[2] set if the addition carried out of bit 2*WIDTH−1; stays set until clear or reset.
- ADD, SUB and MUL do not touch the accumulator.
- Start edge while not IDLE: command ignored; status[15:8] increments, saturating at 255; the in-flight command is unaffected.
- Clear (ctrl_wire[1]=1), evaluated every cycle:
  - Zeroes the accumulator, result_lo, result_hi, status[2], status[3] and status[15:8].
  - Clears done and busy; aborts any in-flight command; forces IDLE.
  - Start-edge history still updates during clear.
- Simultaneous start edge and clear: clear wins; the start is neither executed nor counted.
- Operand wires changing during EXEC: no effect; the latched copies are used.
- done (status[1]) stays high after DONE until the next accepted start, clear or reset.
- Reset asserted mid-operation: immediate return to the reset state; no partial result is ever written.

Test Plan:
- Reset release with ctrl_wire=0x0001 held → no command runs; status_wire=0x0000; drop start then raise it → ADD executes.
- ADD A=0xFFFF, B=0x0001 → at N+2: result_lo=0x0000, result_hi=0x0000, status=0x000A (done, carry); busy high only in cycle N+1.
- SUB A=0x0003, B=0x0005 → result_lo=0xFFFE, result_hi=0xFFFF, status[3]=1; then SUB 5−3 → 0x0002/0x0000, status[3]=0.
- MUL A=0xFFFF, B=0xFFFF → results unchanged through cycle N+16; at N+17: result_hi=0xFFFE, result_lo=0x0001.
- Same cycle: MAC with A=B=0x8000 for 4 starts, then clear → after each MAC acc=0x40000000, 0x80000000, 0xC0000000, 0x00000000 with status[2]=1 on the 4th; clear → results 0 and status=0x0000.
- Start pulsed 3 times during a running MUL → status[15:8]=3; MUL result correct; clear and start asserted together → no execution, count reset to 0.

Source files
------------

// File: rtl/wire_alu_sequencer.sv
// Host-driven ADD/SUB/MUL/MAC command stage: edge-triggered start, multi-cycle shift-add
// multiplier, and result/status wires that only change when a command completes.
module wire_alu_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             ti_clk,
  input  logic             reset,
  input  logic [15:0]      ctrl_wire,
  input  logic [WIDTH-1:0] opa_wire,
  input  logic [WIDTH-1:0] opb_wire,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [15:0]      status_wire
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MAC = 2'b11;

  state_t           state_reg, state_next;
  logic             start_prev_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [RW-1:0]    mcand_reg, prod_reg, acc_reg;
  logic [1:0]       op_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] res_lo_reg, res_hi_reg;
  logic             done_reg, ovf_reg, carry_reg;
  logic [7:0]       ign_cnt_reg;

  logic             start_edge, clear, last_iter, busy;
  logic [WIDTH:0]   add_sum, sub_diff;
  logic [RW-1:0]    prod_sum;
  logic [RW:0]      mac_sum;
  logic             unused_ctrl;

  assign start_edge  = ctrl_wire[0] & ~start_prev_reg;
  assign clear       = ctrl_wire[1];
  assign unused_ctrl = ^ctrl_wire[15:4];

  assign add_sum   = {1'b0, a_reg} + {1'b0, b_reg};
  assign sub_diff  = {1'b0, a_reg} - {1'b0, b_reg};
  assign prod_sum  = prod_reg + (b_reg[0] ? mcand_reg : '0);
  assign mac_sum   = {1'b0, acc_reg} + {1'b0, prod_sum};
  assign last_iter = (cnt_reg == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge ti_clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; clear overrides everything, including a coincident start edge
  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (start_edge) state_next = ST_EXEC;
        ST_EXEC: if (!op_reg[1] || last_iter) state_next = ST_DONE;
        ST_DONE: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy        = (state_reg == ST_EXEC);
    result_lo   = res_lo_reg;
    result_hi   = res_hi_reg;
    status_wire = {ign_cnt_reg, 4'b0000, carry_reg, ovf_reg, done_reg, busy};
  end

  // Datapath and result registers; results are written only on the final EXEC cycle
  always_ff @(posedge ti_clk) begin
    if (reset) begin
      start_prev_reg <= 1'b1;
      a_reg          <= '0;
      b_reg          <= '0;
      mcand_reg      <= '0;
      prod_reg       <= '0;
      acc_reg        <= '0;
      op_reg         <= OP_ADD;
      cnt_reg        <= '0;
      res_lo_reg     <= '0;
      res_hi_reg     <= '0;
      done_reg       <= 1'b0;
      ovf_reg        <= 1'b0;
      carry_reg      <= 1'b0;
      ign_cnt_reg    <= '0;
    end else begin
      start_prev_reg <= ctrl_wire[0];
      if (clear) begin
        acc_reg     <= '0;
        res_lo_reg  <= '0;
        res_hi_reg  <= '0;
        done_reg    <= 1'b0;
        ovf_reg     <= 1'b0;
        carry_reg   <= 1'b0;
        ign_cnt_reg <= '0;
      end else begin
        if (start_edge && state_reg != ST_IDLE && ign_cnt_reg != 8'hFF)
          ign_cnt_reg <= ign_cnt_reg + 8'd1;
        case (state_reg)
          ST_IDLE: begin
            if (start_edge) begin
              a_reg     <= opa_wire;
              b_reg     <= opb_wire;
              mcand_reg <= {{WIDTH{1'b0}}, opa_wire};
              prod_reg  <= '0;
              op_reg    <= ctrl_wire[3:2];
              cnt_reg   <= '0;
              done_reg  <= 1'b0;
            end
          end
          ST_EXEC: begin
            if (op_reg == OP_ADD) begin
              res_lo_reg <= add_sum[WIDTH-1:0];
              res_hi_reg <= '0;
              carry_reg  <= add_sum[WIDTH];
              done_reg   <= 1'b1;
            end else if (op_reg == OP_SUB) begin
              res_lo_reg <= sub_diff[WIDTH-1:0];
              res_hi_reg <= {WIDTH{sub_diff[WIDTH]}};
              carry_reg  <= sub_diff[WIDTH];
              done_reg   <= 1'b1;
            end else begin
              prod_reg  <= prod_sum;
              mcand_reg <= mcand_reg << 1;
              b_reg     <= b_reg >> 1;
              cnt_reg   <= cnt_reg + CW'(1);
              if (last_iter) begin
                done_reg <= 1'b1;
                if (op_reg == OP_MAC) begin
                  acc_reg    <= mac_sum[RW-1:0];
                  res_lo_reg <= mac_sum[WIDTH-1:0];
                  res_hi_reg <= mac_sum[RW-1:WIDTH];
                  if (mac_sum[RW]) ovf_reg <= 1'b1;
                end else begin
                  res_lo_reg <= prod_sum[WIDTH-1:0];
                  res_hi_reg <= prod_sum[RW-1:WIDTH];
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
